// File: rtl/lot_arbiter.sv
// Round-robin arbiter sharing one lottery checker; valid ticket completes 10 cycles after grant, rejected in 2.
// Requesters wait by holding req until their done; no grant is taken while a session is in flight.
module lot_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDW   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req,
    input  logic [20*N_REQ-1:0]  ticket,
    output logic [N_REQ-1:0]     gnt,
    output logic                 busy,
    output logic                 done,
    output logic [IDW-1:0]       done_id,
    output logic [1:0]           done_premio,
    output logic                 done_err,
    output logic                 chk_insere,
    output logic [3:0]           chk_num,
    output logic                 chk_fim,
    output logic                 chk_fim_jogo,
    input  logic [1:0]           chk_premio,
    output logic [7:0]           tickets_cnt
);

    localparam logic [2:0] S_INIT   = 3'd0;
    localparam logic [2:0] S_IDLE   = 3'd1;
    localparam logic [2:0] S_CHECK  = 3'd2;
    localparam logic [2:0] S_DIG    = 3'd3;
    localparam logic [2:0] S_FIM    = 3'd4;
    localparam logic [2:0] S_SAMPLE = 3'd5;
    localparam logic [2:0] S_CLEAR  = 3'd6;
    localparam logic [2:0] S_DONE   = 3'd7;

    logic [2:0]       state;
    logic             live;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   win;
    logic [19:0]      tk_q;
    logic [2:0]       idx;
    logic [N_REQ-1:0] gnt_q;
    logic [1:0]       premio_q;
    logic             err_q;
    logic [7:0]       cnt_q;

    logic             found;
    logic [IDW-1:0]   pick;
    logic [IDW-1:0]   cidx;
    int               c;
    logic [19:0]      sel_tk;
    logic [3:0]       cur_dig;
    logic             tk_bad;

    always_comb begin
        found = 1'b0;
        pick  = '0;
        cidx  = '0;
        c     = 0;
        for (int i = 0; i < N_REQ; i++) begin
            c = int'(rr_ptr) + i;
            if (c >= N_REQ) c = c - N_REQ;
            cidx = c[IDW-1:0];
            if (!found && req[cidx]) begin
                found = 1'b1;
                pick  = cidx;
            end
        end
    end

    always_comb begin
        sel_tk = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (int'(pick) == i) sel_tk = ticket[20*i +: 20];
        end
    end

    always_comb begin
        case (idx)
            3'd0:    cur_dig = tk_q[19:16];
            3'd1:    cur_dig = tk_q[15:12];
            3'd2:    cur_dig = tk_q[11:8];
            3'd3:    cur_dig = tk_q[7:4];
            3'd4:    cur_dig = tk_q[3:0];
            default: cur_dig = 4'd0;
        endcase
    end

    assign tk_bad = (tk_q[19:16] > 4'd9) || (tk_q[15:12] > 4'd9) || (tk_q[11:8] > 4'd9) ||
                    (tk_q[7:4] > 4'd9) || (tk_q[3:0] > 4'd9);

    // live holds outputs quiet while reset is asserted and stretches INIT by one cycle,
    // so the power-up clear pulse appears only after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_INIT;
            live     <= 1'b0;
            rr_ptr   <= '0;
            win      <= '0;
            tk_q     <= '0;
            idx      <= '0;
            gnt_q    <= '0;
            premio_q <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            case (state)
                S_INIT: begin
                    if (!live) live <= 1'b1;
                    else       state <= S_IDLE;
                end
                S_IDLE: begin
                    if (found) begin
                        tk_q  <= sel_tk;
                        win   <= pick;
                        gnt_q <= N_REQ'(1) << pick;
                        state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (tk_bad) begin
                        err_q    <= 1'b1;
                        premio_q <= 2'b00;
                        state    <= S_DONE;
                    end else begin
                        err_q <= 1'b0;
                        idx   <= '0;
                        state <= S_DIG;
                    end
                end
                S_DIG: begin
                    if (idx == 3'd4) begin
                        idx   <= '0;
                        state <= S_FIM;
                    end else begin
                        idx <= idx + 3'd1;
                    end
                end
                S_FIM: state <= S_SAMPLE;
                S_SAMPLE: begin
                    if (chk_premio == 2'b11) begin
                        premio_q <= 2'b00;
                        err_q    <= 1'b1;
                    end else begin
                        premio_q <= chk_premio;
                        err_q    <= 1'b0;
                    end
                    state <= S_CLEAR;
                end
                S_CLEAR: state <= S_DONE;
                S_DONE: begin
                    if (int'(win) == N_REQ - 1) rr_ptr <= '0;
                    else                        rr_ptr <= win + IDW'(1);
                    if (!err_q && cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
                    gnt_q <= '0;
                    state <= S_IDLE;
                end
                default: state <= S_INIT;
            endcase
        end
    end

    assign gnt          = gnt_q;
    assign busy         = live && (state != S_IDLE);
    assign done         = (state == S_DONE);
    assign done_id      = win;
    assign done_premio  = premio_q;
    assign done_err     = err_q;
    assign chk_insere   = (state == S_DIG);
    assign chk_num      = (state == S_DIG) ? cur_dig : 4'd0;
    assign chk_fim      = (state == S_FIM);
    assign chk_fim_jogo = (state == S_CLEAR) || (state == S_INIT && live);
    assign tickets_cnt  = cnt_q;

endmodule

// File: tb/tb_lot_arbiter.sv
// Scoreboard bench for lot_arbiter: stimulus pushes expected results, a negedge monitor checks each done.
module tb_lot_arbiter;
    localparam int N = 4;
    localparam int W = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [20*N-1:0] ticket;
    logic [N-1:0]   gnt;
    logic           busy, done, done_err;
    logic [W-1:0]   done_id;
    logic [1:0]     done_premio;
    logic           chk_insere, chk_fim, chk_fim_jogo;
    logic [3:0]     chk_num;
    logic [1:0]     chk_premio;
    logic [7:0]     tickets_cnt;

    always #5 clk = ~clk;

    lot_arbiter #(.N_REQ(N), .IDW(W)) dut (
        .clk(clk), .reset(reset), .req(req), .ticket(ticket), .gnt(gnt), .busy(busy),
        .done(done), .done_id(done_id), .done_premio(done_premio), .done_err(done_err),
        .chk_insere(chk_insere), .chk_num(chk_num), .chk_fim(chk_fim),
        .chk_fim_jogo(chk_fim_jogo), .chk_premio(chk_premio), .tickets_cnt(tickets_cnt)
    );

    typedef struct {
        int          id;
        logic [19:0] tk;
        int          prem;
        int          err;
        int          lat;
        int          cnt;
        int          ndig;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;
    int m_cnt = 0;

    task automatic chk(input string nm, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at %0t", nm, act, act, exp_v, exp_v, $time);
        end
    endtask

    function automatic int bad_tk(input logic [19:0] t);
        logic [19:0] s;
        for (int k = 0; k < 5; k++) begin
            s = t >> (4 * k);
            if (s[3:0] > 4'd9) return 1;
        end
        return 0;
    endfunction

    function automatic exp_t make_exp(input int id, input logic [19:0] tk, input logic [1:0] prem);
        exp_t e;
        int rej;
        rej    = bad_tk(tk);
        e.id   = id;
        e.tk   = tk;
        e.err  = (rej != 0 || prem == 2'b11) ? 1 : 0;
        e.prem = (rej != 0 || prem == 2'b11) ? 0 : int'(prem);
        e.lat  = (rej != 0) ? 2 : 10;
        e.ndig = (rej != 0) ? 0 : 5;
        if (e.err == 0 && m_cnt < 255) m_cnt++;
        e.cnt  = m_cnt;
        return e;
    endfunction

    task automatic set_tk(input int id, input logic [19:0] tk);
        logic [20*N-1:0] m;
        logic [20*N-1:0] v;
        m = {{(20*N-20){1'b0}}, 20'hFFFFF} << (20 * id);
        v = {{(20*N-20){1'b0}}, tk} << (20 * id);
        ticket = (ticket & ~m) | v;
    endtask

    task automatic session(input int id, input logic [19:0] tk, input logic [1:0] prem);
        int n;
        sb.push_back(make_exp(id, tk, prem));
        set_tk(id, tk);
        chk_premio = prem;
        req = req | (N'(1) << id);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(done && int'(done_id) == id) && n < 60);
        if (!(done && int'(done_id) == id)) chk("session_timeout", 0, 1);
        req = req & ~(N'(1) << id);
    endtask

    // Monitor state
    logic [19:0] dig;
    int ndig, nfim, nclr, lat;
    bit gprev, pend;
    int pend_cnt;
    exp_t e;

    initial begin
        dig = '0; ndig = 0; nfim = 0; nclr = 0; lat = 0; gprev = 0; pend = 0; pend_cnt = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                dig = '0; ndig = 0; nfim = 0; nclr = 0; lat = 0; gprev = 0; pend = 0;
            end else begin
                if (pend) begin
                    chk("tickets_cnt", int'(tickets_cnt), pend_cnt);
                    pend = 0;
                end
                chk("strobe_excl", int'($countones({chk_insere, chk_fim, chk_fim_jogo}) <= 1), 1);
                if (gnt != '0) begin
                    chk("gnt_onehot", int'($onehot(gnt)), 1);
                    lat = gprev ? lat + 1 : 1;
                    if (chk_insere) begin
                        dig = {dig[15:0], chk_num};
                        ndig++;
                    end
                    if (chk_fim) nfim++;
                    if (chk_fim_jogo) nclr++;
                end
                gprev = (gnt != '0);
                if (done) begin
                    chk("done_expected", int'(sb.size() > 0), 1);
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        chk("done_id", int'(done_id), e.id);
                        chk("done_premio", int'(done_premio), e.prem);
                        chk("done_err", int'(done_err), e.err);
                        chk("latency", lat, e.lat);
                        chk("gnt_matches_id", int'(gnt[done_id]), 1);
                        chk("insert_count", ndig, e.ndig);
                        chk("fim_count", nfim, (e.ndig == 5) ? 1 : 0);
                        chk("clear_count", nclr, (e.ndig == 5) ? 1 : 0);
                        if (e.ndig == 5) chk("digit_seq", int'(dig), int'(e.tk));
                        pend = 1;
                        pend_cnt = e.cnt;
                    end
                    dig = '0; ndig = 0; nfim = 0; nclr = 0;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b0; req = '0; ticket = '0; chk_premio = 2'b00;
        #2;
        chk("rst_busy", int'(busy), 0);
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_strobes", int'({chk_insere, chk_fim, chk_fim_jogo}), 0);
        chk("rst_cnt", int'(tickets_cnt), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        n = 0;
        repeat (6) begin
            @(negedge clk);
            if (chk_fim_jogo) n++;
        end
        chk("init_clear_pulses", n, 1);
        chk("idle_busy", int'(busy), 0);
        chk("idle_strobes", int'({chk_insere, chk_fim, chk_fim_jogo}), 0);

        session(0, 20'h47019, 2'b01);
        session(2, 20'h4A019, 2'b01);
        session(3, 20'h12345, 2'b11);

        // All four requesting: pointer is at 0 after terminal 3 finished.
        set_tk(0, 20'h98765);
        set_tk(1, 20'h55555);
        set_tk(2, 20'h01234);
        set_tk(3, 20'h90909);
        chk_premio = 2'b10;
        sb.push_back(make_exp(0, 20'h98765, 2'b10));
        sb.push_back(make_exp(1, 20'h55555, 2'b10));
        sb.push_back(make_exp(2, 20'h01234, 2'b10));
        sb.push_back(make_exp(3, 20'h90909, 2'b10));
        sb.push_back(make_exp(0, 20'h98765, 2'b10));
        req = 4'b1111;
        n = 0;
        for (int t = 0; t < 200 && n < 5; t++) begin
            @(negedge clk);
            if (done) n++;
        end
        chk("rr_done_count", n, 5);
        req = '0;
        repeat (3) @(negedge clk);

        // Reset in the middle of the digit phase.
        set_tk(1, 20'h13579);
        chk_premio = 2'b01;
        req = 4'b0010;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(chk_insere && chk_num == 4'd5) && n < 30);
        chk("reach_dig2", int'(chk_insere && chk_num == 4'd5), 1);
        #2 reset = 1'b0;
        #1;
        chk("midrst_strobes", int'({chk_insere, chk_fim, chk_fim_jogo}), 0);
        chk("midrst_gnt", int'(gnt), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_cnt", int'(tickets_cnt), 0);
        req = '0;
        m_cnt = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        n = 0;
        repeat (6) begin
            @(negedge clk);
            if (chk_fim_jogo) n++;
        end
        chk("reinit_clear_pulses", n, 1);
        chk("reinit_busy", int'(busy), 0);

        for (int i = 0; i < 256; i++) session(0, 20'h24680, 2'b01);
        repeat (3) @(negedge clk);
        chk("cnt_saturated", int'(tickets_cnt), 255);
        chk("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
